cdec_mem_bridge: RTL and testbench



---
 rtl/cdec_pkg.sv | 28 ++
 rtl/cdec_bridge_timer.sv | 31 +++
 rtl/cdec_mem_bridge.sv | 184 ++++++++++++++++++
 tb/tb_cdec_mem_bridge.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdec_pkg.sv
// Shared encodings for the CDEC memory bridge: mmrw field, bridge states,
// error fill data and the timer width helper.
package cdec_pkg;

    typedef enum logic [1:0] {
        MMRW_IDLE = 2'b00,
        MMRW_WR   = 2'b01,
        MMRW_RD   = 2'b10,
        MMRW_RSV  = 2'b11
    } mmrw_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE
    } state_e;

    // Returned to the core on a timed-out read; sliced to DATA_W.
    localparam logic [63:0] ERR_DATA = '1;

    function automatic int timer_w(input int wait_cyc, input int timeout);
        int m;
        m = (wait_cyc > timeout) ? wait_cyc : timeout;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cdec_bridge_timer.sv
// Loadable down-counter shared by the WAIT and ACCESS phases of the bridge.
// Load wins over enable; the count parks at zero.
module cdec_bridge_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset_N,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cdec_mem_bridge.sv
// Handshaked read/write sequencer between the CDEC core mmrw field and a
// variable-latency memory. Define CDEC_MEMBRIDGE_ACCCNT_EN for access counters.
module cdec_mem_bridge
    import cdec_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic              clock,
    input  logic              reset_N,
    input  logic [1:0]        core_mmrw,
    input  logic [ADDR_W-1:0] core_adrs,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              endseq,
    output logic [ADDR_W-1:0] mem_adrs,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic              mem_ready,
    output logic              bus_err
`ifdef CDEC_MEMBRIDGE_ACCCNT_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int TW      = timer_w(WAIT_CYC, TIMEOUT);
    localparam int WAIT_LD = (WAIT_CYC > 0) ? WAIT_CYC - 1 : 0;
    localparam int TO_LD   = TIMEOUT - 1;

    state_e              state_q, state_d;
    mmrw_e               op_q, op_d;
    logic [ADDR_W-1:0]   mem_adrs_q, mem_adrs_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic                mem_wr_en_q, mem_wr_en_d;
    logic                bus_err_q, bus_err_d;
    logic                tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0]       tmr_val;
    logic                req;

    assign req        = ((core_mmrw == MMRW_WR) || (core_mmrw == MMRW_RD)) && !endseq;
    assign core_stall = req && (state_q != DONE);

    cdec_bridge_timer #(.W(TW)) u_timer (
        .clock    (clock),
        .reset_N  (reset_N),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        mem_adrs_d   = mem_adrs_q;
        mem_wdata_d  = mem_wdata_q;
        core_rdata_d = core_rdata_q;
        mem_rd_en_d  = 1'b0;
        mem_wr_en_d  = 1'b0;
        bus_err_d    = bus_err_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        tmr_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    mem_adrs_d  = core_adrs;
                    mem_wdata_d = core_wdata;
                    op_d        = mmrw_e'(core_mmrw);
                    tmr_load    = 1'b1;
                    if (WAIT_CYC > 0) begin
                        state_d = WAIT;
                        tmr_val = TW'(WAIT_LD);
                    end else begin
                        state_d     = ACCESS;
                        tmr_val     = TW'(TO_LD);
                        mem_rd_en_d = (core_mmrw == MMRW_RD);
                        mem_wr_en_d = (core_mmrw == MMRW_WR);
                    end
                end else if ((core_mmrw == MMRW_RSV) && !endseq) begin
                    bus_err_d = 1'b1;
                end
            end
            WAIT: begin
                if (tmr_zero) begin
                    state_d     = ACCESS;
                    tmr_load    = 1'b1;
                    tmr_val     = TW'(TO_LD);
                    mem_rd_en_d = (op_q == MMRW_RD);
                    mem_wr_en_d = (op_q == MMRW_WR);
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ACCESS: begin
                // A ready on the last permitted cycle still completes cleanly.
                if (mem_ready) begin
                    if (op_q == MMRW_RD) core_rdata_d = mem_rdata;
                    state_d = DONE;
                end else if (tmr_zero) begin
                    bus_err_d = 1'b1;
                    if (op_q == MMRW_RD) core_rdata_d = ERR_DATA[DATA_W-1:0];
                    state_d = DONE;
                end else begin
                    tmr_en      = 1'b1;
                    mem_rd_en_d = (op_q == MMRW_RD);
                    mem_wr_en_d = (op_q == MMRW_WR);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_q      <= IDLE;
            op_q         <= MMRW_IDLE;
            mem_adrs_q   <= '0;
            mem_wdata_q  <= '0;
            core_rdata_q <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            mem_adrs_q   <= mem_adrs_d;
            mem_wdata_q  <= mem_wdata_d;
            core_rdata_q <= core_rdata_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_wr_en_q  <= mem_wr_en_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign core_rdata = core_rdata_q;
    assign mem_adrs   = mem_adrs_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_rd_en  = mem_rd_en_q;
    assign mem_wr_en  = mem_wr_en_q;
    assign bus_err    = bus_err_q;

`ifdef CDEC_MEMBRIDGE_ACCCNT_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic        ok_done;

    // Counted on the completing ACCESS cycle so the new value is visible in DONE.
    assign ok_done = (state_q == ACCESS) && mem_ready;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (ok_done && (op_q == MMRW_RD) && (rd_count_q != 16'hFFFF))
            rd_count_d = rd_count_q + 16'd1;
        if (ok_done && (op_q == MMRW_WR) && (wr_count_q != 16'hFFFF))
            wr_count_d = wr_count_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_cdec_mem_bridge.sv
// Randomized bench for cdec_mem_bridge: two instances (WAIT_CYC 0 and 2,
// TIMEOUT 4) checked against a transaction-level model.
module tb_cdec_mem_bridge;
    import cdec_pkg::*;

    localparam int TO = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input int inst, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL u%0d %s: got %0h want %0h at %0t", inst, tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int WC = 2 * g;

        logic       rst_n;
        logic [1:0] core_mmrw;
        logic [7:0] core_adrs, core_wdata, core_rdata;
        logic [7:0] mem_adrs, mem_wdata, mem_rdata;
        logic       core_stall, endseq, mem_wr_en, mem_rd_en, mem_ready, bus_err;
        logic       fin = 1'b0;
`ifdef CDEC_MEMBRIDGE_ACCCNT_EN
        logic [15:0] rd_count, wr_count;
`endif
        logic [7:0] env_mem [256];
        logic [7:0] ref_mem [256];
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_rd, exp_wr;

        cdec_mem_bridge #(.DATA_W(8), .ADDR_W(8), .WAIT_CYC(WC), .TIMEOUT(TO)) u_dut (
            .clock      (clock),
            .reset_N    (rst_n),
            .core_mmrw  (core_mmrw),
            .core_adrs  (core_adrs),
            .core_wdata (core_wdata),
            .core_rdata (core_rdata),
            .core_stall (core_stall),
            .endseq     (endseq),
            .mem_adrs   (mem_adrs),
            .mem_wdata  (mem_wdata),
            .mem_rdata  (mem_rdata),
            .mem_wr_en  (mem_wr_en),
            .mem_rd_en  (mem_rd_en),
            .mem_ready  (mem_ready),
            .bus_err    (bus_err)
`ifdef CDEC_MEMBRIDGE_ACCCNT_EN
            ,
            .rd_count   (rd_count),
            .wr_count   (wr_count)
`endif
        );

        // Entered at a negedge with the bridge in IDLE; d = access cycles before ready.
        task automatic run_txn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd,
                               input int d, input int es_at);
            int acc, done_c;
            logic to, in_acc, exp_st;
            logic [7:0] prev_rd;
            logic prev_err;
            core_mmrw = op; core_adrs = a; core_wdata = wd; mem_ready = 1'b0;
            #1;
            prev_rd  = exp_rdata;
            prev_err = exp_err;
            chk(g, "stall_c0", core_stall, 1);
            chk(g, "rdata_c0", core_rdata, prev_rd);
            to     = (d >= TO);
            acc    = to ? TO : d + 1;
            done_c = 1 + WC + acc;
            if (op == MMRW_RD) exp_rdata = to ? 8'hFF : ref_mem[a];
            else if (!to)      ref_mem[a] = wd;
            if (to) exp_err = 1'b1;
            else if (op == MMRW_RD) begin if (exp_rd != 65535) exp_rd++; end
            else begin if (exp_wr != 65535) exp_wr++; end
            for (int i = 1; i <= done_c; i++) begin
                @(negedge clock);
                in_acc = (i > WC) && (i <= WC + acc);
                exp_st = (i < done_c) && !(es_at > 0 && i > es_at);
                chk(g, "rd_en", mem_rd_en, in_acc && (op == MMRW_RD));
                chk(g, "wr_en", mem_wr_en, in_acc && (op == MMRW_WR));
                chk(g, "stall", core_stall, exp_st);
                if (in_acc) begin
                    chk(g, "mem_adrs", mem_adrs, a);
                    if (op == MMRW_WR) chk(g, "mem_wdata", mem_wdata, wd);
                end
                if (i < done_c) begin
                    chk(g, "rdata_hold", core_rdata, prev_rd);
                    chk(g, "err_hold", bus_err, prev_err);
                end else begin
                    chk(g, "rdata_done", core_rdata, exp_rdata);
                    chk(g, "err_done", bus_err, exp_err);
`ifdef CDEC_MEMBRIDGE_ACCCNT_EN
                    chk(g, "rd_count", rd_count, exp_rd);
                    chk(g, "wr_count", wr_count, exp_wr);
`endif
                end
                if (i == es_at) endseq = 1'b1;
                if (in_acc) begin
                    mem_ready = (i - WC - 1 == d);
                    mem_rdata = env_mem[mem_adrs];
                    if (mem_ready && mem_wr_en) env_mem[mem_adrs] = mem_wdata;
                end else begin
                    mem_ready = 1'b0;
                end
            end
        endtask

        task automatic run_rsv();
            core_mmrw = MMRW_RSV;
            #1 chk(g, "rsv_stall0", core_stall, 0);
            @(negedge clock);
            exp_err = 1'b1;
            chk(g, "rsv_err", bus_err, 1);
            chk(g, "rsv_rd_en", mem_rd_en, 0);
            chk(g, "rsv_wr_en", mem_wr_en, 0);
            chk(g, "rsv_stall", core_stall, 0);
            core_mmrw = MMRW_IDLE;
        endtask

        initial begin
            logic [1:0] op;
            int d, gap, r;
            logic prev_txn;
            rst_n = 1'b0; core_mmrw = 2'b00; core_adrs = '0; core_wdata = '0;
            endseq = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
            exp_rdata = '0; exp_err = 1'b0; exp_rd = 0; exp_wr = 0;
            for (int k = 0; k < 256; k++) begin
                env_mem[k] = 8'($urandom);
                ref_mem[k] = env_mem[k];
            end
            env_mem[8'h3C] = 8'hA5; ref_mem[8'h3C] = 8'hA5;
            repeat (2) @(negedge clock);
            chk(g, "rst_rdata", core_rdata, 0);
            chk(g, "rst_adrs", mem_adrs, 0);
            chk(g, "rst_wdata", mem_wdata, 0);
            chk(g, "rst_rd_en", mem_rd_en, 0);
            chk(g, "rst_wr_en", mem_wr_en, 0);
            chk(g, "rst_err", bus_err, 0);
            chk(g, "rst_stall", core_stall, 0);
            rst_n = 1'b1;
            @(negedge clock);

            run_txn(MMRW_RD, 8'h3C, 8'h00, 0, -1);
            core_mmrw = MMRW_IDLE; @(negedge clock);
            run_txn(MMRW_WR, 8'h10, 8'h5A, 2, -1);
            core_mmrw = MMRW_IDLE; @(negedge clock);
            run_txn(MMRW_RD, 8'h77, 8'h00, 255, -1);
            core_mmrw = MMRW_IDLE; @(negedge clock);
            run_rsv();

            prev_txn = 1'b0;
            for (int n = 0; n < 40; n++) begin
                r  = $urandom_range(0, 11);
                op = (r < 6) ? MMRW_RD : ((r < 11) ? MMRW_WR : MMRW_RSV);
                d  = ($urandom_range(0, 5) == 0) ? 255 : $urandom_range(0, TO);
                gap = $urandom_range(0, 2);
                if (gap == 0 && prev_txn) begin
                    core_mmrw = op;
                    #1 chk(g, "stall_in_done", core_stall, 0);
                    @(negedge clock);
                end else begin
                    core_mmrw = MMRW_IDLE;
                    repeat ((gap == 0) ? 1 : gap) @(negedge clock);
                end
                if (op == MMRW_RSV) begin
                    run_rsv();
                    prev_txn = 1'b0;
                end else begin
                    run_txn(op, 8'($urandom), 8'($urandom), d, -1);
                    prev_txn = 1'b1;
                end
            end

            core_mmrw = MMRW_IDLE; @(negedge clock);
            core_mmrw = MMRW_RD; core_adrs = 8'h42;
            repeat (WC + 1) @(negedge clock);
            chk(g, "pre_rst_rd_en", mem_rd_en, 1);
            chk(g, "pre_rst_err", bus_err, exp_err);
            rst_n = 1'b0;
            #1;
            chk(g, "arst_rd_en", mem_rd_en, 0);
            chk(g, "arst_err", bus_err, 0);
            chk(g, "arst_rdata", core_rdata, 0);
            exp_err = 1'b0; exp_rdata = '0; exp_rd = 0; exp_wr = 0;
            core_mmrw = MMRW_IDLE;
            @(negedge clock);
            rst_n = 1'b1;
            @(negedge clock);
            run_txn(MMRW_RD, 8'h42, 8'h00, 1, -1);

            exp_rd = 0; exp_wr = 0;
            rst_n = 1'b0; core_mmrw = MMRW_IDLE; exp_rdata = '0; exp_err = 1'b0;
            @(negedge clock);
            rst_n = 1'b1;
            for (int k = 0; k < 6; k++) begin
                core_mmrw = MMRW_IDLE; @(negedge clock);
                run_txn((k < 3 || k == 5) ? MMRW_RD : MMRW_WR, 8'($urandom), 8'($urandom),
                        (k == 5) ? 255 : $urandom_range(0, 2), -1);
            end
`ifdef CDEC_MEMBRIDGE_ACCCNT_EN
            chk(g, "rd_count_3", rd_count, 3);
            chk(g, "wr_count_2", wr_count, 2);
`endif

            core_mmrw = MMRW_IDLE; @(negedge clock);
            run_txn(MMRW_RD, 8'h3C, 8'h00, 1, 1);
            for (int k = 0; k < 6; k++) begin
                @(negedge clock);
                chk(g, "es_rd_en", mem_rd_en, 0);
                chk(g, "es_wr_en", mem_wr_en, 0);
                chk(g, "es_stall", core_stall, 0);
            end
            fin = 1'b1;
        end
    end

    initial begin
        for (int k = 0; k < 20000; k++) begin
            @(posedge clock);
            if (g_dut[0].fin && g_dut[1].fin) break;
        end
        chk(9, "bench_finish", {31'b0, g_dut[0].fin && g_dut[1].fin}, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
